run_controller: RTL and testbench

Top-level run sequencer for the ternary system. It owns the IDLE/LOADING/EXECUTING/HALTED system state and drives the loader start pulse and CPU enable/reset. It also arbitrates the single instruction/data memory write port between the program loader and the CPU, and declares the program finished when the PC stalls in fetch or a cycle budget expires. It sits between `system`'s loader, CPU and memory instances.

---
 rtl/run_controller.sv | 134 +++++++++++++
 tb/tb_run_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// run_controller: sequences IDLE/LOADING/EXECUTING/HALTED, arbitrates the shared
// memory write port between loader and CPU, and detects PC-stall halt or cycle-budget timeout.
module run_controller #(
    parameter int WORD_W      = 18,
    parameter int ADDR_W      = 18,
    parameter int HALT_CYCLES = 5,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              loader_done,
    input  logic              loader_mem_write,
    input  logic [ADDR_W-1:0] loader_mem_addr,
    input  logic [WORD_W-1:0] loader_mem_wdata,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [WORD_W-1:0] cpu_mem_wdata,
    input  logic [WORD_W-1:0] cpu_pc,
    input  logic              cpu_in_fetch,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              loader_start,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic [1:0]        system_state,
    output logic              halted,
    output logic              timeout,
    output logic [15:0]       cycle_count
);
    localparam int SW = $clog2(HALT_CYCLES + 1);
    localparam logic [SW-1:0] HALT_U = SW'(HALT_CYCLES);
    localparam logic [31:0]   MAX_U  = MAX_CYCLES;

    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_EXECUTING, S_HALTED} state_t;

    state_t            r_state;
    logic              r_loader_start;
    logic              r_cpu_reset;
    logic              r_cpu_enable;
    logic              r_halted;
    logic              r_timeout;
    logic [15:0]       r_cycle_count;
    logic [SW-1:0]     r_stall_cnt;
    logic [WORD_W-1:0] r_prev_pc;
    logic              r_prev_valid;

    logic              w_load_own;
    logic              w_cpu_own;
    logic [SW-1:0]     w_stall_next;
    logic [15:0]       w_cycle_next;
    logic              w_stall_done;
    logic              w_budget_done;

    // The first fetch after entering EXECUTING has no valid prev_pc and never counts as a stall.
    always_comb begin
        w_stall_next  = !cpu_in_fetch ? r_stall_cnt :
                        (r_prev_valid && cpu_pc == r_prev_pc) ? r_stall_cnt + 1'b1 : '0;
        w_cycle_next  = (r_cycle_count == 16'hFFFF) ? r_cycle_count : r_cycle_count + 16'd1;
        w_stall_done  = w_stall_next >= HALT_U;
        w_budget_done = {16'd0, w_cycle_next} >= MAX_U;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_loader_start <= 1'b0;
            r_cpu_reset    <= 1'b1;
            r_cpu_enable   <= 1'b0;
            r_halted       <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
            r_stall_cnt    <= '0;
            r_prev_pc      <= '0;
            r_prev_valid   <= 1'b0;
        end else begin
            r_loader_start <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_state        <= S_LOADING;
                        r_loader_start <= 1'b1;
                        r_cpu_reset    <= 1'b1;
                        r_cpu_enable   <= 1'b0;
                        r_halted       <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_cycle_count  <= '0;
                        r_stall_cnt    <= '0;
                        r_prev_valid   <= 1'b0;
                    end
                end
                S_LOADING: begin
                    if (loader_done) begin
                        r_state      <= S_EXECUTING;
                        r_cpu_reset  <= 1'b0;
                        r_cpu_enable <= 1'b1;
                        r_stall_cnt  <= '0;
                        r_prev_valid <= 1'b0;
                    end
                end
                S_EXECUTING: begin
                    r_cycle_count <= w_cycle_next;
                    r_stall_cnt   <= w_stall_next;
                    if (cpu_in_fetch) begin
                        r_prev_pc    <= cpu_pc;
                        r_prev_valid <= 1'b1;
                    end
                    // A stall completing on the budget cycle reports as a normal halt.
                    if (w_stall_done || w_budget_done) begin
                        r_state      <= S_HALTED;
                        r_cpu_enable <= 1'b0;
                        r_halted     <= w_stall_done;
                        r_timeout    <= !w_stall_done;
                    end
                end
            endcase
        end
    end

    assign w_load_own = (r_state == S_LOADING);
    assign w_cpu_own  = (r_state == S_EXECUTING);

    assign mem_write    = (w_load_own & loader_mem_write) | (w_cpu_own & cpu_mem_write);
    assign mem_addr     = w_load_own ? loader_mem_addr  : w_cpu_own ? cpu_mem_addr  : '0;
    assign mem_wdata    = w_load_own ? loader_mem_wdata : w_cpu_own ? cpu_mem_wdata : '0;
    assign loader_start = r_loader_start;
    assign cpu_reset    = r_cpu_reset;
    assign cpu_enable   = r_cpu_enable;
    assign system_state = r_state;
    assign halted       = r_halted;
    assign timeout      = r_timeout;
    assign cycle_count  = r_cycle_count;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed checks of sequencing, arbitration, stall halt and timeout.
module tb_run_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        loader_done;
    logic        loader_mem_write;
    logic [17:0] loader_mem_addr;
    logic [17:0] loader_mem_wdata;
    logic        cpu_mem_write;
    logic [17:0] cpu_mem_addr;
    logic [17:0] cpu_mem_wdata;
    logic [17:0] cpu_pc;
    logic        cpu_in_fetch;
    logic        mem_write;
    logic [17:0] mem_addr;
    logic [17:0] mem_wdata;
    logic        loader_start;
    logic        cpu_reset;
    logic        cpu_enable;
    logic [1:0]  system_state;
    logic        halted;
    logic        timeout;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr = 0;
    logic [17:0] wr_addr [16];
    logic [17:0] wr_data [16];

    run_controller #(.WORD_W(18), .ADDR_W(18), .HALT_CYCLES(5), .MAX_CYCLES(50)) dut (
        .clock(clock), .reset(reset), .start(start), .loader_done(loader_done),
        .loader_mem_write(loader_mem_write), .loader_mem_addr(loader_mem_addr),
        .loader_mem_wdata(loader_mem_wdata), .cpu_mem_write(cpu_mem_write),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_pc(cpu_pc),
        .cpu_in_fetch(cpu_in_fetch), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .loader_start(loader_start), .cpu_reset(cpu_reset),
        .cpu_enable(cpu_enable), .system_state(system_state), .halted(halted),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Memory-side log of every write that actually reaches the port.
    always @(posedge clock) begin
        if (mem_write && n_wr < 16) begin
            wr_addr[n_wr] <= mem_addr;
            wr_data[n_wr] <= mem_wdata;
        end
        if (mem_write) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; loader_done = 1'b0;
        loader_mem_write = 1'b0; loader_mem_addr = '0; loader_mem_wdata = '0;
        cpu_mem_write = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
        cpu_pc = '0; cpu_in_fetch = 1'b0;
        tick; tick;
        reset = 1'b0;
        check("rst_state", system_state, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_loader_start", loader_start, 0);
        check("rst_halted", halted, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycles", cycle_count, 0);

        // Idle: a CPU write strobe must not reach memory.
        cpu_mem_write = 1'b1; cpu_mem_addr = 18'h3ffff; cpu_mem_wdata = 18'h2aaaa;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_state", system_state, 0);
            check("idle_cpu_reset", cpu_reset, 1);
            check("idle_mem_write", mem_write, 0);
        end

        // Load with a competing CPU strobe every cycle.
        start = 1'b1;
        tick;
        start = 1'b0;
        check("load_state", system_state, 1);
        check("load_pulse", loader_start, 1);
        check("load_cpu_reset", cpu_reset, 1);
        check("load_cpu_enable", cpu_enable, 0);
        for (int i = 0; i < 4; i++) begin
            loader_mem_write = 1'b1;
            loader_mem_addr = 18'(i);
            loader_mem_wdata = 18'(i + 1);
            loader_done = (i == 3);
            #1;
            check("load_mem_write", mem_write, 1);
            check("load_mem_addr", mem_addr, i);
            check("load_mem_wdata", mem_wdata, i + 1);
            tick;
            check("load_pulse_off", loader_start, 0);
        end
        loader_mem_write = 1'b0; loader_done = 1'b0; cpu_mem_write = 1'b0;
        check("exec_state", system_state, 2);
        check("exec_cpu_reset", cpu_reset, 0);
        check("exec_cpu_enable", cpu_enable, 1);
        check("exec_cycles0", cycle_count, 0);
        check("mem_wr_count", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            check("mem_log_addr", wr_addr[i], i);
            check("mem_log_data", wr_data[i], i + 1);
        end

        // In EXECUTING the CPU owns the port; loader strobe is dropped.
        cpu_mem_write = 1'b1; cpu_mem_addr = 18'h00123; cpu_mem_wdata = 18'h00456;
        loader_mem_write = 1'b1; loader_mem_addr = 18'h00777; loader_mem_wdata = 18'h00888;
        #1;
        check("exec_mem_write", mem_write, 1);
        check("exec_mem_addr", mem_addr, 18'h00123);
        check("exec_mem_wdata", mem_wdata, 18'h00456);
        cpu_mem_write = 1'b0; loader_mem_write = 1'b0;
        #1;
        check("exec_loader_dropped", mem_write, 0);

        // PC stall: 0,1,2,3,3,3,(non-fetch 7),3,3,3 -> fifth equal compare on cycle 9.
        for (int c = 0; c < 10; c++) begin
            cpu_pc = (c == 6) ? 18'd7 : (c < 3 ? 18'(c) : 18'd3);
            cpu_in_fetch = (c != 6);
            #1;
            check("stall_running", system_state, 2);
            tick;
        end
        cpu_in_fetch = 1'b0;
        cpu_mem_write = 1'b1;
        #1;
        check("stall_state", system_state, 3);
        check("stall_halted", halted, 1);
        check("stall_timeout", timeout, 0);
        check("stall_cycles", cycle_count, 10);
        check("stall_cpu_enable", cpu_enable, 0);
        check("stall_cpu_reset", cpu_reset, 0);
        check("halted_mem_write", mem_write, 0);
        check("halted_mem_addr", mem_addr, 0);
        cpu_mem_write = 1'b0;
        tick;
        check("halted_hold", system_state, 3);

        // Rerun from HALTED clears flags and pulses the loader.
        start = 1'b1;
        tick;
        start = 1'b0;
        check("rerun_state", system_state, 1);
        check("rerun_pulse", loader_start, 1);
        check("rerun_halted", halted, 0);
        check("rerun_cycles", cycle_count, 0);
        check("rerun_cpu_reset", cpu_reset, 1);
        loader_done = 1'b1;
        tick;
        loader_done = 1'b0;
        check("rerun_exec", system_state, 2);

        // Timeout: PC advances every fetch, start ignored mid-run.
        for (int c = 0; c < 50; c++) begin
            cpu_pc = 18'(c + 100);
            cpu_in_fetch = 1'b1;
            start = (c >= 10 && c < 13);
            #1;
            check("to_running", system_state, 2);
            tick;
        end
        start = 1'b0; cpu_in_fetch = 1'b0;
        check("to_state", system_state, 3);
        check("to_timeout", timeout, 1);
        check("to_halted", halted, 0);
        check("to_cycles", cycle_count, 50);
        check("to_cpu_enable", cpu_enable, 0);

        // Reset mid-execution.
        start = 1'b1; tick; start = 1'b0;
        loader_done = 1'b1; tick; loader_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cpu_pc = 18'(c); cpu_in_fetch = 1'b1;
            tick;
        end
        check("mid_cycles_pre", cycle_count, 5);
        reset = 1'b1;
        tick;
        reset = 1'b0; cpu_in_fetch = 1'b0;
        check("mid_rst_state", system_state, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_cycles", cycle_count, 0);
        check("mid_rst_enable", cpu_enable, 0);
        start = 1'b1; tick; start = 1'b0;
        check("reload_state", system_state, 1);
        check("reload_pulse", loader_start, 1);
        loader_done = 1'b1; tick; loader_done = 1'b0;
        check("reload_exec", system_state, 2);

        // Stall completes on the same cycle the budget expires.
        for (int c = 0; c < 50; c++) begin
            cpu_pc = (c < 44) ? 18'(c) : 18'd500;
            cpu_in_fetch = 1'b1;
            #1;
            check("both_running", system_state, 2);
            tick;
        end
        cpu_in_fetch = 1'b0;
        check("both_state", system_state, 3);
        check("both_halted", halted, 1);
        check("both_timeout", timeout, 0);
        check("both_cycles", cycle_count, 50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
